// File: rtl/uart_defs.sv
// uart_defs: shared receiver constants, FSM state encoding and baud divider rounding
package uart_defs;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_e;
  // Fixed oversampling ratio; the top-level OVERSAMPLE parameter is checked against it.
  localparam int OS_RATIO = 16;
  localparam int MID_LO = 7;
  localparam int MID_HI = 9;
  // Clocks per oversample tick, rounded to nearest: (F + 8B) / 16B.
  function automatic int tick_div(input int clock_freq, input int baud_rate);
    return int'((longint'(clock_freq) + longint'(baud_rate) * 8) / (longint'(baud_rate) * 16));
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing one-cycle 16x oversample ticks
//   clk   in  clock
//   reset in  asynchronous active-high reset, clears the divider
//   tick  out one-cycle pulse each time the divider wraps
module uart_baud_tick
  import uart_defs::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int DIV = tick_div(CLOCK_FREQ, BAUD_RATE);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled 8N1 UART receiver with majority vote, glitch rejection and error flags
//   clk            in   single clock domain
//   reset          in   asynchronous active-high reset
//   serial_in      in   raw RX pin, idle high
//   data_out       out  received byte, LSB = first data bit
//   data_out_valid out  byte held until accepted
//   data_out_ready in   consumer accepts on valid & ready
//   framing_error  out  one-cycle pulse, stop bit sampled low
//   overrun        out  one-cycle pulse, byte completed while holding register full
module uart_rx_os16
  import uart_defs::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);
  localparam int SW = $clog2(OS_RATIO);
  if (OVERSAMPLE != OS_RATIO) begin : g_os_check
    $error("uart_rx_os16: OVERSAMPLE must be 16");
  end
  logic tick, rx_s, rx_prev_q, mid, maj, accept;
  logic [1:0] sync_q, samp_q, samp_d;
  rx_state_e state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, fe_q, fe_d, ovr_q, ovr_d;
  uart_baud_tick #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tick (
    .clk(clk),
    .reset(reset),
    .tick(tick)
  );
  assign rx_s = sync_q[1];
  assign mid = tick && s_q == SW'(MID_HI);
  // samp_q holds the s=7 and s=8 samples; the s=9 sample is rx_s on the mid tick itself.
  assign maj = (samp_q[0] & samp_q[1]) | (rx_s & (samp_q[0] | samp_q[1]));
  assign accept = valid_q && data_out_ready;
  always_comb begin
    state_d = state_q;
    s_d = tick ? s_q + SW'(1) : s_q;
    idx_d = idx_q;
    shift_d = shift_q;
    samp_d = samp_q;
    data_d = data_q;
    valid_d = valid_q && !accept;
    fe_d = 1'b0;
    ovr_d = 1'b0;
    if (tick && s_q == SW'(MID_LO)) samp_d[0] = rx_s;
    if (tick && s_q == SW'(MID_LO + 1)) samp_d[1] = rx_s;
    case (state_q)
      IDLE:
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          s_d = '0;
        end
      START:
        if (mid) begin
          state_d = maj ? IDLE : DATA;
          idx_d = 3'd0;
        end
      DATA:
        if (mid) begin
          shift_d = {maj, shift_q[7:1]};
          idx_d = idx_q + 3'd1;
          state_d = (idx_q == 3'd7) ? STOP : DATA;
        end
      STOP:
        if (mid) begin
          state_d = maj ? IDLE : BRK;
          fe_d = !maj;
          // A load may coincide with the consumer taking the previous byte.
          if (maj && (!valid_q || data_out_ready)) begin
            data_d = shift_q;
            valid_d = 1'b1;
          end
          ovr_d = maj && valid_q && !data_out_ready;
        end
      BRK: state_d = rx_s ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q <= IDLE;
      s_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      samp_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      fe_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], serial_in};
      rx_prev_q <= rx_s;
      state_q <= state_d;
      s_q <= s_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      samp_q <= samp_d;
      data_q <= data_d;
      valid_q <= valid_d;
      fe_q <= fe_d;
      ovr_q <= ovr_d;
    end
  assign data_out = data_q;
  assign data_out_valid = valid_q;
  assign framing_error = fe_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: vector table, directed corner sequences and random frames against a frame-level model
module tb_uart_rx_os16;
  localparam int BIT = 128;
  logic clk = 1'b0, reset = 1'b1, serial_in = 1'b1;
  logic rdy_fix = 1'b1, rdy_rand = 1'b0, rdy_sel = 1'b0;
  logic data_out_ready, data_out_valid, framing_error, overrun;
  logic [7:0] data_out;
  int checks = 0, failures = 0;
  logic [7:0] rx_log [0:255];
  int rx_n = 0, rd = 0, fe_cnt = 0, ovr_cnt = 0, both_cnt = 0, vcnt = 0;
  typedef struct {
    logic [7:0] data;
    logic stop;
    int gb;
    int exp_n;
    int exp_fe;
    logic [7:0] exp_d;
  } vec_t;
  vec_t vecs [8];
  logic [7:0] expq [$];
  assign data_out_ready = rdy_sel ? rdy_rand : rdy_fix;
  always #4 clk = ~clk;
  uart_rx_os16 #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(125_000), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .reset(reset),
    .serial_in(serial_in),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error(framing_error),
    .overrun(overrun)
  );
  always @(posedge clk) #1 rdy_rand = 1'($urandom_range(0, 1));
  always @(negedge clk)
    if (!reset) begin
      if (data_out_valid && data_out_ready) begin
        rx_log[rx_n % 256] = data_out;
        rx_n++;
      end
      if (data_out_valid) vcnt++;
      if (framing_error) fe_cnt++;
      if (overrun) ovr_cnt++;
      if (framing_error && overrun) both_cnt++;
    end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic idle(input int n);
    serial_in = 1'b1;
    step(n);
  endtask
  task automatic hold_low(input int n);
    serial_in = 1'b0;
    step(n);
  endtask
  // Drives the first nb bits of an 8N1 frame; gb selects a bit carrying a 7-clk inverted pulse.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int blen, input int gb, input int nb);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nb; i++)
      for (int c = 0; c < blen; c++) begin
        @(posedge clk);
        #1;
        serial_in = f[i] ^ (i == gb && c >= 64 && c < 71);
      end
  endtask
  task automatic chk_rx(input string nm, input int en, input logic [7:0] ed);
    chk({nm, "_count"}, rx_n - rd, en);
    if (en > 0 && rx_n > rd) chk({nm, "_data"}, int'(rx_log[(rx_n - 1) % 256]), int'(ed));
    rd = rx_n;
  endtask
  initial begin
    int fe0, ov0, vc0, efe, en;
    logic [7:0] d;
    logic stop;
    int gb;
    vecs[0] = '{8'hA5, 1'b1, -1, 1, 0, 8'hA5};
    vecs[1] = '{8'h55, 1'b0, -1, 0, 1, 8'h00};
    vecs[2] = '{8'h81, 1'b1, -1, 1, 0, 8'h81};
    vecs[3] = '{8'h5A, 1'b1, 4, 1, 0, 8'h5A};
    vecs[4] = '{8'h0F, 1'b1, -1, 1, 0, 8'h0F};
    vecs[5] = '{8'h00, 1'b1, 2, 1, 0, 8'h00};
    vecs[6] = '{8'hFF, 1'b1, 7, 1, 0, 8'hFF};
    vecs[7] = '{8'h00, 1'b0, -1, 0, 1, 8'h00};
    step(3);
    chk("rst_data", int'(data_out), 0);
    chk("rst_valid", int'(data_out_valid), 0);
    chk("rst_fe", int'(framing_error), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      fe0 = fe_cnt;
      ov0 = ovr_cnt;
      vc0 = vcnt;
      send_frame(vecs[i].data, vecs[i].stop, BIT, vecs[i].gb, 10);
      idle(2 * BIT);
      chk_rx($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_d);
      chk($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
      chk($sformatf("vec%0d_ovr", i), ovr_cnt - ov0, 0);
      chk($sformatf("vec%0d_vcyc", i), vcnt - vc0, vecs[i].exp_n);
    end
    rdy_fix = 1'b0;
    fe0 = fe_cnt;
    ov0 = ovr_cnt;
    send_frame(8'h3C, 1'b1, BIT, -1, 10);
    send_frame(8'hC3, 1'b1, BIT, -1, 10);
    idle(BIT);
    chk("ovr_pulse", ovr_cnt - ov0, 1);
    chk("ovr_valid", int'(data_out_valid), 1);
    chk("ovr_data", int'(data_out), 'h3C);
    chk("ovr_fe", fe_cnt - fe0, 0);
    rdy_fix = 1'b1;
    step(2);
    chk("ovr_drop", int'(data_out_valid), 0);
    chk_rx("ovr", 1, 8'h3C);
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, BIT, -1, 10);
    hold_low(20 * BIT);
    chk("brk_fe", fe_cnt - fe0, 1);
    chk("brk_valid", int'(data_out_valid), 0);
    idle(2 * BIT);
    send_frame(8'h81, 1'b1, BIT, -1, 10);
    idle(2 * BIT);
    chk_rx("brk", 1, 8'h81);
    chk("brk_fe_once", fe_cnt - fe0, 1);
    fe0 = fe_cnt;
    ov0 = ovr_cnt;
    hold_low(35);
    idle(2 * BIT);
    chk_rx("glitch", 0, 8'h00);
    chk("glitch_fe", fe_cnt - fe0, 0);
    chk("glitch_ovr", ovr_cnt - ov0, 0);
    send_frame(8'h0F, 1'b1, BIT, -1, 10);
    idle(2 * BIT);
    chk_rx("glitch_next", 1, 8'h0F);
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b1, BIT, -1, 4);
    reset = 1'b1;
    #1;
    chk("rstmid_valid", int'(data_out_valid), 0);
    step(3);
    reset = 1'b0;
    idle(2 * BIT);
    chk_rx("rstmid", 0, 8'h00);
    chk("rstmid_fe", fe_cnt - fe0, 0);
    rdy_fix = 1'b0;
    send_frame(8'h12, 1'b1, BIT, -1, 10);
    idle(BIT);
    chk("held_valid", int'(data_out_valid), 1);
    chk("held_data", int'(data_out), 'h12);
    reset = 1'b1;
    #1;
    chk("rstval_valid", int'(data_out_valid), 0);
    chk("rstval_data", int'(data_out), 0);
    step(3);
    reset = 1'b0;
    rdy_fix = 1'b1;
    idle(BIT);
    chk_rx("rstval", 0, 8'h00);
    send_frame(8'h12, 1'b1, 130, -1, 10);
    idle(2 * BIT);
    chk_rx("skew_slow", 1, 8'h12);
    send_frame(8'h12, 1'b1, 126, -1, 10);
    idle(2 * BIT);
    chk_rx("skew_fast", 1, 8'h12);
    rdy_sel = 1'b1;
    fe0 = fe_cnt;
    ov0 = ovr_cnt;
    efe = 0;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
      gb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 9)) : -1;
      if (stop) expq.push_back(d);
      else efe++;
      send_frame(d, stop, BIT, gb, 10);
      idle(int'($urandom_range(16, 200)));
    end
    idle(2 * BIT);
    en = expq.size();
    chk("rand_count", rx_n - rd, en);
    for (int k = 0; k < en && rd < rx_n; k++) begin
      chk($sformatf("rand_byte%0d", k), int'(rx_log[rd % 256]), int'(expq[k]));
      rd++;
    end
    chk("rand_fe", fe_cnt - fe0, efe);
    chk("rand_ovr", ovr_cnt - ov0, 0);
    chk("fe_ovr_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
